wb_sram_responder: RTL and testbench
====================================

# wb_sram_responder

Wishbone B4 responder (slave) fronting a single-port on-chip word SRAM, the target end of the CFU's RAM master port. Serves classic single-beat cycles and registered-feedback bursts (constant and incrementing, linear or wrapping). Used as the CFU-private scratchpad and as the bench target for the CFU RAM master.

## Interface
- ADDR_WIDTH, 10: word-address bits decoded; depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 0: extra cycles inserted before the first ack of every cycle (0..15).
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- wb_adr  in  30  word address.
- wb_dat_mosi  in  32  write data.
- wb_sel  in  4  byte lane enables; bit i covers bits 8i+7..8i.
- wb_cyc, wb_stb, wb_we  in  1 each  Wishbone cycle/strobe/write-enable.
- wb_cti  in  3  000 classic, 001 constant burst, 010 incrementing burst, 111 end of burst; others reserved.
- wb_bte  in  2  00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- wb_dat_miso  out  32  read data, valid while wb_ack=1.
- wb_ack  out  1  beat completed normally.
- wb_err  out  1  beat completed with error.

## Operation
- Reset: wb_ack=0, wb_err=0, wb_dat_miso=0, state IDLE, pointer 0, wait counter 0. SRAM contents not reset.
- States: IDLE, WAIT, CLASSIC_ACK, BURST.
- IDLE: on wb_cyc&wb_stb, capture wb_adr into pointer, wb_cti/wb_bte into burst type; go WAIT if WAIT_STATES>0 else issue first beat response.
- WAIT: count WAIT_STATES cycles, then issue first beat response. cyc drop → IDLE.
- Beat response: register ack (or err) plus read data for the current pointer. Classic (cti 000 or 111 at start) → CLASSIC_ACK; cti 001/010 → BURST.
- CLASSIC_ACK: ack high exactly one cycle; return IDLE. Next request sampled only from IDLE.
- BURST: a beat completes on each edge with wb_stb&(wb_ack|wb_err). On completion, if the beat's wb_cti=111 → deassert next cycle, IDLE; else advance pointer and keep responding every cycle while wb_stb=1. wb_stb=0 mid-burst → response deasserts next cycle, pointer held, resumes on wb_stb=1.
- Pointer advance: 001 no change; 010 linear +1; wrap-N increments low log2(N) bits only, upper bits fixed.
- Write: on the completing edge with wb_we=1 and ack, update SRAM at pointer for lanes with wb_sel=1; other lanes unchanged. wb_sel=0000 completes with ack, no change.
- Read: wb_dat_miso = word at pointer for the acked beat, all 4 lanes regardless of wb_sel.
- Error: pointer[29:ADDR_WIDTH]≠0 or reserved cti (011..110) → wb_err instead of wb_ack for that beat, no write, wb_dat_miso=0. Burst continues; later in-range beats ack.
- wb_cyc=0 in any state → IDLE next edge, no write that edge, ack/err low next cycle.
- wb_ack and wb_err never both 1.

## Timing
- Classic latency: request seen at edge N → ack high in cycle N+1+WAIT_STATES, one cycle wide.
- Back-to-back classic: minimum period 2+WAIT_STATES cycles.
- Burst: first beat as classic, then one beat per cycle with stb held; N-beat burst occupies N+1+WAIT_STATES cycles.
- Read data for beat k+1 registered during beat k; zero bubble for linear and wrap.
- Write visible to a read issued on the cycle after the writing ack.
- Reset assert mid-cycle: outputs to reset values immediately (asynchronous), no partial write after release.

## Test plan
- WAIT_STATES=0: classic write 0xDEADBEEF to 0x005 sel 1111, then read 0x005 → ack one cycle each, read data 0xDEADBEEF; write 0x000000AA sel 0001 → read 0xDEADBEAA.
- WAIT_STATES=3: classic read → ack exactly 4 cycles after stb seen.
- Preload 0x10..0x13 with 1..4; cti 010 bte 00 read from 0x10, cti 111 on 4th beat → acks 4 consecutive cycles, data 1,2,3,4, then ack low, IDLE.
- Wrap-4 incrementing read from 0x06 → addresses 6,7,4,5; master drops stb for 2 cycles after beat 2 → ack gap, resumes with 4,5.
- Address 0x400 with ADDR_WIDTH=10 write → wb_err one cycle, ack 0, SRAM unchanged; cti 101 → wb_err.
- Drop wb_cyc mid 8-beat write burst after beat 3 → only 3 words written, ack low next cycle; reset_n low mid-burst → ack/err/dat_miso 0 immediately, IDLE after release.

Source files
------------

// File: rtl/wb_sram_responder.sv
// wb_sram_responder
//   Wishbone B4 responder in front of a single-port 32-bit word SRAM.
//   It serves classic single-beat cycles and registered-feedback bursts:
//   constant, incrementing linear, and incrementing wrap-4/8/16.
//   A beat gets wb_err instead of wb_ack when its address is outside the
//   decoded range, or when the cycle starts with a reserved cti. An error
//   beat writes nothing and returns zero read data.
// Ports
//   clk, reset_n       clock; asynchronous active-low reset
//   wb_adr[29:0]       word address
//   wb_dat_mosi[31:0]  write data
//   wb_sel[3:0]        byte lane enables
//   wb_cyc/stb/we      cycle, strobe, write enable
//   wb_cti[2:0]        cycle type identifier
//   wb_bte[1:0]        burst type extension
//   wb_dat_miso[31:0]  read data, valid while wb_ack=1
//   wb_ack, wb_err     normal / error beat termination
module wb_sram_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] wb_adr,
    input  logic [31:0] wb_dat_mosi,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [2:0]  wb_cti,
    input  logic [1:0]  wb_bte,
    output logic [31:0] wb_dat_miso,
    output logic        wb_ack,
    output logic        wb_err
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [2:0]  CTI_CONST = 3'b001;
    localparam logic [2:0]  CTI_INCR  = 3'b010;
    localparam logic [2:0]  CTI_EOB   = 3'b111;

    typedef enum logic [1:0] {IDLE, WAIT, CLASSIC_ACK, BURST} state_e;

    state_e      state_q, state_d;
    logic [29:0] ptr_q, ptr_d;
    logic [2:0]  cti_q, cti_d;
    logic [1:0]  bte_q, bte_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;

    logic [31:0] mem [DEPTH];

    logic        resp;
    logic        resp_bad;
    logic [29:0] resp_ptr;
    logic [29:0] ptr_nxt;
    logic        mem_we;
    logic [31:0] wr_word;

    function automatic logic [29:0] advance(input logic [29:0] p, input logic [2:0] cti,
                                            input logic [1:0] bte);
        logic [29:0] inc;
        logic [29:0] mask;
        inc = p + 30'd1;
        case (bte)
            2'b01:   mask = 30'h3;
            2'b10:   mask = 30'h7;
            2'b11:   mask = 30'hF;
            default: mask = '1;
        endcase
        // Wrap bursts carry only inside the low bits; linear uses a full mask.
        if (cti == CTI_CONST) return p;
        return (p & ~mask) | (inc & mask);
    endfunction

    function automatic logic out_of_range(input logic [29:0] p);
        return (p >> ADDR_WIDTH) != '0;
    endfunction

    function automatic logic cti_reserved(input logic [2:0] c);
        return (c >= 3'b011) && (c <= 3'b110);
    endfunction

    function automatic logic is_burst(input logic [2:0] c);
        return (c == CTI_CONST) || (c == CTI_INCR);
    endfunction

    assign ptr_nxt = advance(ptr_q, cti_q, bte_q);

    // Merged word for a masked write. It is also forwarded to a same-edge
    // read of the same word, as happens in a constant-address burst.
    always_comb begin
        wr_word = mem[ptr_q[ADDR_WIDTH-1:0]];
        for (int unsigned i = 0; i < 4; i++) begin
            if (wb_sel[i]) wr_word[8*i +: 8] = wb_dat_mosi[8*i +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cti_d    = cti_q;
        bte_d    = bte_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = '0;
        resp     = 1'b0;
        resp_bad = 1'b0;
        resp_ptr = ptr_q;
        mem_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    ptr_d = wb_adr;
                    cti_d = wb_cti;
                    bte_d = wb_bte;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else begin
                        resp     = 1'b1;
                        resp_ptr = wb_adr;
                        resp_bad = cti_reserved(wb_cti);
                        state_d  = is_burst(wb_cti) ? BURST : CLASSIC_ACK;
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    resp     = 1'b1;
                    resp_bad = cti_reserved(cti_q);
                    state_d  = is_burst(cti_q) ? BURST : CLASSIC_ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CLASSIC_ACK: begin
                state_d = IDLE;
                mem_we  = wb_cyc && wb_stb && wb_we && ack_q;
            end
            BURST: begin
                if (!wb_cyc) begin
                    state_d = IDLE;
                end else if (wb_stb && (ack_q || err_q)) begin
                    mem_we = wb_we && ack_q;
                    if (wb_cti == CTI_EOB) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d    = ptr_nxt;
                        resp     = 1'b1;
                        resp_ptr = ptr_nxt;
                    end
                end else if (wb_stb) begin
                    // Master resumed after a strobe gap: re-serve the held pointer.
                    resp = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (resp) begin
            if (resp_bad || out_of_range(resp_ptr)) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (mem_we && (resp_ptr == ptr_q)) dat_d = wr_word;
                else                               dat_d = mem[resp_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cti_q   <= '0;
            bte_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_q[ADDR_WIDTH-1:0]] <= wr_word;
    end

    assign wb_ack      = ack_q;
    assign wb_err      = err_q;
    assign wb_dat_miso = dat_q;

endmodule

// File: tb/tb_wb_sram_responder.sv
module tb_wb_sram_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] adr;
    logic [31:0] mosi;
    logic [3:0]  sel;
    logic        cyc0, stb0, cyc3, stb3, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] miso0, miso3;
    logic        ack0, err0, ack3, err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_sram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .wb_adr(adr), .wb_dat_mosi(mosi), .wb_sel(sel),
        .wb_cyc(cyc0), .wb_stb(stb0), .wb_we(we), .wb_cti(cti), .wb_bte(bte),
        .wb_dat_miso(miso0), .wb_ack(ack0), .wb_err(err0));

    wb_sram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .wb_adr(adr), .wb_dat_mosi(mosi), .wb_sel(sel),
        .wb_cyc(cyc3), .wb_stb(stb3), .wb_we(we), .wb_cti(cti), .wb_bte(bte),
        .wb_dat_miso(miso3), .wb_ack(ack3), .wb_err(err3));

    typedef struct {
        int          which;
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: no response within cycle budget", nm);
    endtask

    task automatic sample(input int which, output logic a, output logic e, output logic [31:0] d);
        if (which == 3) begin a = ack3; e = err3; d = miso3; end
        else            begin a = ack0; e = err0; d = miso0; end
    endtask

    task automatic bus_idle();
        cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
        we = 1'b0; cti = 3'b000; bte = 2'b00; sel = 4'hF;
    endtask

    task automatic run_classic(input vec_t v, input string nm);
        int          n;
        logic        a, e;
        logic [31:0] d;
        @(posedge clk); #1;
        we = v.we; adr = v.adr; mosi = v.dat; sel = v.sel; cti = v.cti; bte = 2'b00;
        if (v.which == 3) begin cyc3 = 1'b1; stb3 = 1'b1; end
        else              begin cyc0 = 1'b1; stb0 = 1'b1; end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            sample(v.which, a, e, d);
        end while (!(a || e) && n < 20);
        if (!(a || e)) begin
            timeout({nm, "_resp"});
            bus_idle();
            return;
        end
        check({nm, "_lat"}, 32'(n), (v.which == 3) ? 32'd4 : 32'd1);
        check({nm, "_ack"}, {31'd0, a}, {31'd0, v.exp_ack});
        check({nm, "_err"}, {31'd0, e}, {31'd0, v.exp_err});
        if (v.chk_dat) check({nm, "_dat"}, d, v.exp_dat);
        @(posedge clk); #1;
        bus_idle();
        sample(v.which, a, e, d);
        check({nm, "_onecyc"}, {30'd0, a, e}, 32'd0);
    endtask

    function automatic vec_t mk(input int which, input logic w, input logic [29:0] a,
                                input logic [31:0] dt, input logic [3:0] s, input logic [2:0] c,
                                input logic ea, input logic ee, input logic cd,
                                input logic [31:0] ed);
        vec_t v;
        v.which = which; v.we = w; v.adr = a; v.dat = dt; v.sel = s; v.cti = c;
        v.exp_ack = ea; v.exp_err = ee; v.chk_dat = cd; v.exp_dat = ed;
        return v;
    endfunction

    task automatic wr(input logic [29:0] a, input logic [31:0] dt, input string nm);
        run_classic(mk(0, 1'b1, a, dt, 4'hF, 3'b000, 1'b1, 1'b0, 1'b0, 32'd0), nm);
    endtask

    task automatic rd(input logic [29:0] a, input logic [31:0] ed, input string nm);
        run_classic(mk(0, 1'b0, a, 32'd0, 4'hF, 3'b000, 1'b1, 1'b0, 1'b1, ed), nm);
    endtask

    // Wait for the first beat of a burst on dut0.
    task automatic wait_first(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(ack0 || err0) && n < 20);
        if (!(ack0 || err0)) timeout(nm);
        else check({nm, "_lat"}, 32'(n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        adr = '0; mosi = '0;
        bus_idle();

        vecs.push_back(mk(0, 1, 30'h005, 32'hDEADBEEF, 4'hF, 3'b000, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 30'h005, 32'h0,        4'hF, 3'b000, 1, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 30'h005, 32'h000000AA, 4'h1, 3'b000, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 30'h005, 32'h0,        4'hF, 3'b000, 1, 0, 1, 32'hDEADBEAA));
        vecs.push_back(mk(0, 1, 30'h005, 32'h12345678, 4'h0, 3'b000, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 30'h005, 32'h0,        4'h0, 3'b000, 1, 0, 1, 32'hDEADBEAA));
        vecs.push_back(mk(0, 1, 30'h000, 32'hCAFEF00D, 4'hF, 3'b000, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 30'h400, 32'h11111111, 4'hF, 3'b000, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 0, 30'h000, 32'h0,        4'hF, 3'b000, 1, 0, 1, 32'hCAFEF00D));
        vecs.push_back(mk(0, 0, 30'h005, 32'h0,        4'hF, 3'b101, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 1, 30'h3FF, 32'h01234567, 4'hF, 3'b000, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 30'h3FF, 32'hABCD9999, 4'hC, 3'b000, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 30'h3FF, 32'h0,        4'hF, 3'b111, 1, 0, 1, 32'hABCD4567));
        vecs.push_back(mk(3, 1, 30'h005, 32'h5A5A5A5A, 4'hF, 3'b000, 1, 0, 0, 32'h0));
        vecs.push_back(mk(3, 0, 30'h005, 32'h0,        4'hF, 3'b000, 1, 0, 1, 32'h5A5A5A5A));

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_err0", {31'd0, err0}, 32'd0);
        check("rst_dat0", miso0, 32'd0);
        check("rst_out3", {29'd0, ack3, err3, |miso3}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_classic(vecs[i], $sformatf("v%0d", i));

        // Linear incrementing read burst, end-of-burst on beat 4.
        for (int k = 0; k < 4; k++) wr(30'h10 + 30'(k), 32'(k + 1), $sformatf("preA%0d", k));
        @(posedge clk); #1;
        adr = 30'h10; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc0 = 1'b1; stb0 = 1'b1;
        wait_first("lin");
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            check($sformatf("lin_ack%0d", k), {31'd0, ack0}, 32'd1);
            check($sformatf("lin_dat%0d", k), miso0, 32'(k + 1));
            if (k == 3) cti = 3'b111;
        end
        @(posedge clk); #1;
        check("lin_end", {30'd0, ack0, err0}, 32'd0);
        bus_idle();
        @(posedge clk); #1;
        check("lin_idle", {30'd0, ack0, err0}, 32'd0);

        // Wrap-4 read from 6 with a two-cycle strobe gap after beat 2.
        for (int k = 0; k < 5; k++) wr(30'h4 + 30'(k), 32'h40 + 32'(k), $sformatf("preB%0d", k));
        @(posedge clk); #1;
        adr = 30'h6; we = 1'b0; cti = 3'b010; bte = 2'b01; cyc0 = 1'b1; stb0 = 1'b1;
        wait_first("wrap");
        check("wrap_d6", miso0, 32'h42);
        @(posedge clk); #1;
        check("wrap_d7", miso0, 32'h43);
        @(posedge clk); #1;
        stb0 = 1'b0;
        @(posedge clk); #1;
        check("wrap_gap1", {31'd0, ack0}, 32'd0);
        @(posedge clk); #1;
        check("wrap_gap2", {31'd0, ack0}, 32'd0);
        stb0 = 1'b1;
        @(posedge clk); #1;
        check("wrap_ack4", {31'd0, ack0}, 32'd1);
        check("wrap_d4", miso0, 32'h40);
        @(posedge clk); #1;
        check("wrap_ack5", {31'd0, ack0}, 32'd1);
        check("wrap_d5", miso0, 32'h41);
        cti = 3'b111;
        @(posedge clk); #1;
        check("wrap_end", {30'd0, ack0, err0}, 32'd0);
        bus_idle();

        // Write burst abandoned by dropping cyc after beat 3.
        for (int k = 0; k < 4; k++) wr(30'h20 + 30'(k), 32'h0, $sformatf("preC%0d", k));
        @(posedge clk); #1;
        adr = 30'h20; we = 1'b1; sel = 4'hF; cti = 3'b010; bte = 2'b00;
        mosi = 32'h101; cyc0 = 1'b1; stb0 = 1'b1;
        wait_first("wb");
        @(posedge clk); #1;
        check("wb_ack2", {31'd0, ack0}, 32'd1);
        mosi = 32'h102;
        @(posedge clk); #1;
        check("wb_ack3", {31'd0, ack0}, 32'd1);
        mosi = 32'h103;
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk); #1;
        check("wb_drop", {30'd0, ack0, err0}, 32'd0);
        for (int k = 0; k < 4; k++)
            rd(30'h20 + 30'(k), (k < 3) ? 32'h101 + 32'(k) : 32'h0, $sformatf("wbrd%0d", k));

        // Asynchronous reset in the middle of a burst.
        @(posedge clk); #1;
        adr = 30'h10; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc0 = 1'b1; stb0 = 1'b1;
        wait_first("rstb");
        check("rstb_d0", miso0, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstb_async", {29'd0, ack0, err0, |miso0}, 32'd0);
        bus_idle();
        @(posedge clk);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rstb_after", {30'd0, ack0, err0}, 32'd0);
        rd(30'h10, 32'd1, "rstb_rd0");
        rd(30'h11, 32'd2, "rstb_rd1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
